// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between instruction fetch and LSU
//
// Serialises IF reads and LSU reads/writes onto one synchronous RAM, one
// transaction in flight at a time (IDLE -> ISSUE -> [WAIT] -> DONE).
// Default policy: LSU priority, IF forced after STARVE_MAX consecutive LSU
// grants while IF waits. Build macro ARB_RR_EN selects round-robin instead.
//
// Ports:
//   CLK, N_RST                 clock, asynchronous active-low reset
//   IF_REQ/IF_ADDR/IF_FLUSH    fetch request, address, redirect abort
//   IF_ACK/IF_RDATA            fetch completion pulse and fetched word
//   LSU_REQ/WE/ADDR/WDATA      load/store request
//   LSU_ACK/LSU_RDATA          load/store completion pulse and load data
//   MEM_CE/WE/ADDR/WDATA       registered RAM command, active only in ISSUE
//   MEM_RDATA                  RAM read data, RD_LAT cycles after MEM_CE
//   OWNER                      0 = IF, 1 = LSU (current or last grant)

module mem_port_arbiter #(
   parameter int AW         = 11,
   parameter int DW         = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          CLK,
   input  logic          N_RST,
   input  logic          IF_REQ,
   input  logic [AW-1:0] IF_ADDR,
   input  logic          IF_FLUSH,
   output logic          IF_ACK,
   output logic [DW-1:0] IF_RDATA,
   input  logic          LSU_REQ,
   input  logic          LSU_WE,
   input  logic [AW-1:0] LSU_ADDR,
   input  logic [DW-1:0] LSU_WDATA,
   output logic          LSU_ACK,
   output logic [DW-1:0] LSU_RDATA,
   output logic          MEM_CE,
   output logic          MEM_WE,
   output logic [AW-1:0] MEM_ADDR,
   output logic [DW-1:0] MEM_WDATA,
   input  logic [DW-1:0] MEM_RDATA,
   output logic          OWNER
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          mem_ce_q, mem_ce_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]    lat_q, lat_d;
   logic          flush_pend_q, flush_pend_d;
   logic          if_ack_q, if_ack_d;
   logic          lsu_ack_q, lsu_ack_d;
   logic [DW-1:0] if_buf_q, if_buf_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] lsu_rdata_q, lsu_rdata_d;
   logic          if_req_eff;
   logic          grant_lsu;
   logic          if_flush_now;
   logic          if_ack_eff;
`ifndef ARB_RR_EN
   logic [3:0]    starve_q, starve_d;
`endif

   // A flush in IDLE hides the fetch request for that cycle.
   assign if_req_eff = IF_REQ & ~IF_FLUSH;

`ifdef ARB_RR_EN
   assign grant_lsu = LSU_REQ & (~if_req_eff | ~owner_q);
`else
   assign grant_lsu = LSU_REQ & (~if_req_eff | (starve_q != 4'(STARVE_MAX)));
`endif

   // Only an IF-owned transaction can be flushed.
   assign if_flush_now = ~owner_q & (flush_pend_q | IF_FLUSH);

   // Fetch data is staged in if_buf_q so a flush arriving in DONE can still
   // suppress both the ACK and the IF_RDATA update in that same cycle.
   assign if_ack_eff = if_ack_q & ~if_flush_now;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      mem_ce_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      lat_d        = lat_q;
      flush_pend_d = flush_pend_q;
      if_ack_d     = 1'b0;
      lsu_ack_d    = 1'b0;
      if_buf_d     = if_buf_q;
      if_rdata_d   = if_rdata_q;
      lsu_rdata_d  = lsu_rdata_q;
`ifndef ARB_RR_EN
      starve_d     = starve_q;
`endif
      case (state_q)
         IDLE: begin
            flush_pend_d = 1'b0;
            if (if_req_eff | LSU_REQ) begin
               state_d     = ISSUE;
               owner_d     = grant_lsu;
               mem_ce_d    = 1'b1;
               mem_we_d    = grant_lsu & LSU_WE;
               mem_addr_d  = grant_lsu ? LSU_ADDR : IF_ADDR;
               mem_wdata_d = (grant_lsu & LSU_WE) ? LSU_WDATA : '0;
            end
`ifndef ARB_RR_EN
            // Counts LSU wins over a waiting fetch; anything else resets it.
            if (if_req_eff & grant_lsu)
               starve_d = (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
            else
               starve_d = '0;
`endif
         end
         ISSUE: begin
            flush_pend_d = if_flush_now;
            if (mem_we_q) begin
               lsu_ack_d = 1'b1;
               state_d   = DONE;
            end else begin
               lat_d   = 2'(RD_LAT - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            flush_pend_d = if_flush_now;
            if (lat_q != 2'd0) begin
               lat_d = lat_q - 2'd1;
            end else if (if_flush_now) begin
               // Flushed fetch: the RAM read is done, drop it without an ACK.
               flush_pend_d = 1'b0;
               state_d      = IDLE;
            end else begin
               state_d = DONE;
               if (owner_q) begin
                  lsu_ack_d   = 1'b1;
                  lsu_rdata_d = MEM_RDATA;
               end else begin
                  if_ack_d = 1'b1;
                  if_buf_d = MEM_RDATA;
               end
            end
         end
         DONE: begin
            state_d      = IDLE;
            flush_pend_d = 1'b0;
            if (if_ack_eff)
               if_rdata_d = if_buf_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         mem_ce_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         lat_q        <= '0;
         flush_pend_q <= 1'b0;
         if_ack_q     <= 1'b0;
         lsu_ack_q    <= 1'b0;
         if_buf_q     <= '0;
         if_rdata_q   <= '0;
         lsu_rdata_q  <= '0;
`ifndef ARB_RR_EN
         starve_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         mem_ce_q     <= mem_ce_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         lat_q        <= lat_d;
         flush_pend_q <= flush_pend_d;
         if_ack_q     <= if_ack_d;
         lsu_ack_q    <= lsu_ack_d;
         if_buf_q     <= if_buf_d;
         if_rdata_q   <= if_rdata_d;
         lsu_rdata_q  <= lsu_rdata_d;
`ifndef ARB_RR_EN
         starve_q     <= starve_d;
`endif
      end
   end

   assign IF_ACK    = if_ack_eff;
   assign IF_RDATA  = if_ack_eff ? if_buf_q : if_rdata_q;
   assign LSU_ACK   = lsu_ack_q;
   assign LSU_RDATA = lsu_rdata_q;
   assign MEM_CE    = mem_ce_q;
   assign MEM_WE    = mem_we_q;
   assign MEM_ADDR  = mem_addr_q;
   assign MEM_WDATA = mem_wdata_q;
   assign OWNER     = owner_q;

endmodule
